// File: rtl/regfile_seq_rand_if.sv
// Bus bundle for regfile_seq_rand: append write, sequential/random
// read requests, read result, occupancy and sticky error flags.
interface regfile_seq_rand_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  clr;
  logic                  we;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  seq_re;
  logic                  rewind;
  logic                  ran_re;
  logic [ADDR_WIDTH-1:0] ran_r_addr;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;
  logic                  addr_err;
  logic                  conflict;

  modport master (
    output clr, we, w_data, seq_re, rewind, ran_re, ran_r_addr,
    input  r_valid, r_addr, r_data, count, full, empty,
    input  overflow, underflow, addr_err, conflict
  );

  modport slave (
    input  clr, we, w_data, seq_re, rewind, ran_re, ran_r_addr,
    output r_valid, r_addr, r_data, count, full, empty,
    output overflow, underflow, addr_err, conflict
  );
endinterface

// File: rtl/regfile_seq_rand.sv
// Append-only register file with a sequential read pointer and random
// read port; single-cycle read latency and sticky error flags.
module regfile_seq_rand #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  regfile_seq_rand_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  ran_oob;

  assign full    = (wr_ptr == PW'(DEPTH));
  assign empty   = (rd_ptr == wr_ptr);
  assign do_wr   = bus.we && !full && !bus.clr;
  assign ran_oob = ({1'b0, bus.ran_r_addr} >= wr_ptr);

  assign bus.count = wr_ptr;
  assign bus.full  = full;
  assign bus.empty = empty;

  // storage: append at wr_ptr, contents survive reset and clear
  always_ff @(posedge clk) begin
    if (!rst && do_wr)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.w_data;
  end

  // pointers, read result and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.r_valid   <= 1'b0;
      bus.r_addr    <= '0;
      bus.r_data    <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.addr_err  <= 1'b0;
      bus.conflict  <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.r_valid   <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.addr_err  <= 1'b0;
      bus.conflict  <= 1'b0;
    end else begin
      bus.r_valid <= 1'b0;
      if (bus.we) begin
        if (full)
          bus.overflow <= 1'b1;
        else
          wr_ptr <= wr_ptr + 1'b1;
      end
      if (bus.rewind) begin
        rd_ptr <= '0;
      end else if (bus.seq_re) begin
        if (bus.ran_re)
          bus.conflict <= 1'b1;
        if (empty) begin
          bus.underflow <= 1'b1;
        end else begin
          bus.r_valid <= 1'b1;
          bus.r_addr  <= rd_ptr[ADDR_WIDTH-1:0];
          bus.r_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
          rd_ptr      <= rd_ptr + 1'b1;
        end
      end else if (bus.ran_re) begin
        bus.r_valid <= 1'b1;
        bus.r_addr  <= bus.ran_r_addr;
        if (ran_oob) begin
          bus.r_data   <= '0;
          bus.addr_err <= 1'b1;
        end else begin
          bus.r_data <= mem[bus.ran_r_addr];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_seq_rand.sv
// Self-checking bench for regfile_seq_rand (DEPTH=8, DATA_WIDTH=32):
// directed scenarios then random traffic against a word-level model.
module tb_regfile_seq_rand;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic clk = 0;
  logic rst = 1;
  int   errors = 0;
  int   checks = 0;

  regfile_seq_rand_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_seq_rand #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wr, m_rd;
  bit            m_valid;
  int            m_raddr;
  logic [DW-1:0] m_rdata;
  bit            m_ovf, m_und, m_aerr, m_conf;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_valid = 0;
    m_raddr = 0; m_rdata = '0;
    m_ovf = 0; m_und = 0; m_aerr = 0; m_conf = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".r_valid"}, 64'(bus.r_valid), 64'(m_valid));
    chk({tag, ".r_addr"}, 64'(bus.r_addr), 64'(m_raddr));
    chk({tag, ".r_data"}, 64'(bus.r_data), 64'(m_rdata));
    chk({tag, ".count"}, 64'(bus.count), 64'(m_wr));
    chk({tag, ".full"}, 64'(bus.full), 64'(m_wr == DEPTH));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(m_rd == m_wr));
    chk({tag, ".flags"},
        64'({bus.overflow, bus.underflow, bus.addr_err, bus.conflict}),
        64'({m_ovf, m_und, m_aerr, m_conf}));
  endtask

  // one clock with given requests; model applies the rules on
  // pre-edge state, then outputs are compared 1ns after the edge
  task automatic step(string tag, bit w, logic [DW-1:0] d, bit s,
                      bit rw, bit ra, int a, bit c);
    int pw, pr;
    bus.we = w; bus.w_data = d; bus.seq_re = s;
    bus.rewind = rw; bus.ran_re = ra;
    bus.ran_r_addr = AW'(a); bus.clr = c;
    @(posedge clk);
    pw = m_wr; pr = m_rd;
    m_valid = 0;
    if (c) begin
      m_wr = 0; m_rd = 0;
      m_ovf = 0; m_und = 0; m_aerr = 0; m_conf = 0;
    end else begin
      if (w) begin
        if (pw == DEPTH) m_ovf = 1;
        else begin m_mem[pw] = d; m_wr = pw + 1; end
      end
      if (rw) m_rd = 0;
      else if (s) begin
        if (ra) m_conf = 1;
        if (pr == pw) m_und = 1;
        else begin
          m_valid = 1; m_raddr = pr;
          m_rdata = m_mem[pr]; m_rd = pr + 1;
        end
      end else if (ra) begin
        m_valid = 1; m_raddr = a;
        if (a >= pw) begin m_rdata = '0; m_aerr = 1; end
        else m_rdata = m_mem[a];
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic wr(string t, logic [DW-1:0] d);
    step(t, 1, d, 0, 0, 0, 0, 0);
  endtask
  task automatic idle(string t);
    step(t, 0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.clr = 0; bus.we = 0; bus.w_data = '0; bus.seq_re = 0;
    bus.rewind = 0; bus.ran_re = 0; bus.ran_r_addr = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.empty_const", 64'(bus.empty), 64'd1);
    @(negedge clk); rst = 0;

    // sequential append and drain
    wr("s1_w0", 32'h01020304);
    wr("s1_w1", 32'h05060708);
    wr("s1_w2", 32'h090A0B0C);
    step("s1_r0", 0, '0, 1, 0, 0, 0, 0);
    chk("s1_r0_data", 64'(bus.r_data), 64'h01020304);
    step("s1_r1", 0, '0, 1, 0, 0, 0, 0);
    step("s1_r2", 0, '0, 1, 0, 0, 0, 0);
    chk("s1_r2_addr", 64'(bus.r_addr), 64'd2);
    step("s1_under", 0, '0, 1, 0, 0, 0, 0);
    chk("s1_under_flag", 64'(bus.underflow), 64'd1);

    // fill, overflow, random read of last word
    step("s2_clr", 0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++)
      wr("s2_fill", 32'hA0000000 + i);
    wr("s2_ovf", 32'hDEADBEEF);
    chk("s2_count", 64'(bus.count), 64'd8);
    step("s2_ran7", 0, '0, 0, 0, 1, 7, 0);
    chk("s2_ran7_data", 64'(bus.r_data), 64'hA0000007);

    // out-of-range random read and rd_ptr independence
    step("s3_clr", 0, '0, 0, 0, 0, 0, 1);
    wr("s3_w0", 32'h11111111);
    wr("s3_w1", 32'h22222222);
    wr("s3_w2", 32'h33333333);
    step("s3_ran5", 0, '0, 0, 0, 1, 5, 0);
    chk("s3_aerr", 64'(bus.addr_err), 64'd1);
    step("s3_ran1", 0, '0, 0, 0, 1, 1, 0);
    idle("s3_hold");

    // conflict then rewind with seq_re
    step("s4_conf", 0, '0, 1, 0, 1, 2, 0);
    chk("s4_conf_addr", 64'(bus.r_addr), 64'd0);
    step("s4_rew", 0, '0, 1, 1, 0, 0, 0);
    step("s4_after", 0, '0, 1, 0, 0, 0, 0);

    // partial drain, clear, new write lands at 0
    step("s5_r0", 0, '0, 1, 0, 0, 0, 0);
    step("s5_clr", 0, '0, 0, 0, 0, 0, 1);
    wr("s5_w", 32'hCAFEF00D);
    step("s5_ran0", 0, '0, 0, 0, 1, 0, 0);
    step("s5_wr_rd", 1, 32'h12345678, 1, 0, 0, 0, 0);

    // asynchronous reset just after an accepted seq_re
    bus.seq_re = 1; bus.we = 0; bus.ran_re = 0;
    bus.rewind = 0; bus.clr = 0;
    @(posedge clk);
    #3; rst = 1; #1;
    model_reset();
    check_all("s6_async");
    @(negedge clk); rst = 0;
    idle("s6_next");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 99) < 45,
           $urandom,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 99) < 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
